// File: rtl/tx_source_scheduler_if.sv
// Requester-side bus of the transmit source scheduler: request/word inputs,
// ack pulses, mux select and the serial line.
interface tx_source_scheduler_if #(
  parameter int unsigned W = 8
);
  logic [3:0]     req;
  logic [4*W-1:0] data_in;
  logic [3:0]     ack;
  logic [1:0]     mux_sel;
  logic           busy;
  logic           tx;

  modport slave  (input req, data_in, output ack, mux_sel, busy, tx);
  modport master (output req, data_in, input ack, mux_sel, busy, tx);
endinterface

// File: rtl/tx_source_scheduler.sv
// Round-robin grant of four requesters onto one UART-style serial line:
// start bit, W data bits LSB-first, stop bit, CLKS_PER_BIT clocks per bit.
module tx_source_scheduler #(
  parameter int unsigned W            = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic                   clk,
  input  logic                   rstb,
  tx_source_scheduler_if.slave   bus
);
  localparam int unsigned BIT_CNT_W = $clog2(W + 1);
  localparam int unsigned CLK_CNT_W = $clog2(CLKS_PER_BIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e               state_q,   state_d;
  logic [W-1:0]         shift_q,   shift_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CLK_CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [1:0]           last_q,    last_d;
  logic [1:0]           sel_q,     sel_d;
  logic [3:0]           ack_q,     ack_d;
  logic                 busy_q,    busy_d;
  logic                 tx_q,      tx_d;

  logic [1:0] winner_c;
  logic       found_c;
  logic       bit_end_c;

  // First requester after the last grant, wrapping modulo 4.
  always_comb begin
    logic [1:0] idx;
    idx      = '0;
    winner_c = '0;
    found_c  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found_c && bus.req[idx]) begin
        winner_c = idx;
        found_c  = 1'b1;
      end
    end
  end

  assign bit_end_c = (clk_cnt_q == CLK_CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      clk_cnt_q <= '0;
      last_q    <= 2'd3;
      sel_q     <= '0;
      ack_q     <= '0;
      busy_q    <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      clk_cnt_q <= clk_cnt_d;
      last_q    <= last_d;
      sel_q     <= sel_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      tx_q      <= tx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    clk_cnt_d = clk_cnt_q;
    last_d    = last_q;
    sel_d     = sel_q;
    ack_d     = '0;
    busy_d    = busy_q;
    tx_d      = tx_q;

    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (found_c) begin
          sel_d     = winner_c;
          shift_d   = bus.data_in[32'(winner_c) * W +: W];
          ack_d     = 4'b0001 << winner_c;
          last_d    = winner_c;
          busy_d    = 1'b1;
          tx_d      = 1'b0;
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (bit_end_c) begin
          clk_cnt_d = '0;
          tx_d      = shift_q[0];
          state_d   = S_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end_c) begin
          clk_cnt_d = '0;
          if (bit_cnt_q == BIT_CNT_W'(W - 1)) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            shift_d   = shift_q >> 1;
            tx_d      = shift_d[0];
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_CNT_W'(1);
        end
      end
      S_STOP: begin
        if (bit_end_c) begin
          clk_cnt_d = '0;
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.ack     = ack_q;
  assign bus.mux_sel = sel_q;
  assign bus.busy    = busy_q;
  assign bus.tx      = tx_q;
endmodule

// File: tb/tb_tx_source_scheduler.sv
// Bench for tx_source_scheduler: a frame-level reference model checked every
// cycle on two instances (4 and 1 clocks per bit) plus literal expectations.
module tb_tx_source_scheduler;
  localparam int W    = 8;
  localparam int CPB0 = 4;
  localparam int CPB1 = 1;

  logic clk = 1'b0;
  logic rstb;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  tx_source_scheduler_if #(.W(W)) if0 ();
  tx_source_scheduler_if #(.W(W)) if1 ();

  tx_source_scheduler #(.W(W), .CLKS_PER_BIT(CPB0)) u_dut0 (.clk(clk), .rstb(rstb), .bus(if0));
  tx_source_scheduler #(.W(W), .CLKS_PER_BIT(CPB1)) u_dut1 (.clk(clk), .rstb(rstb), .bus(if1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: a frame is an array of W+2 line bits, each held cpb cycles.
  logic       m_act  [2];
  int         m_e    [2];
  int         m_last [2];
  logic [1:0] m_sel  [2];
  logic [3:0] m_ack  [2];
  logic [7:0] m_word [2];

  always @(posedge clk or negedge rstb) begin
    for (int k = 0; k < 2; k++) begin
      logic [3:0]  r;
      logic [31:0] d;
      int          cpb;
      int          w;
      r   = (k == 0) ? if0.req : if1.req;
      d   = (k == 0) ? if0.data_in : if1.data_in;
      cpb = (k == 0) ? CPB0 : CPB1;
      if (!rstb) begin
        m_act[k] = 1'b0; m_e[k] = 0; m_last[k] = 3; m_sel[k] = 2'd0; m_ack[k] = 4'd0;
        m_word[k] = 8'd0;
      end else begin
        m_ack[k] = 4'd0;
        if (m_act[k]) begin
          m_e[k]++;
          if (m_e[k] == (W + 2) * cpb) m_act[k] = 1'b0;
        end else if (r != 4'd0) begin
          w = -1;
          for (int j = 1; j <= 4; j++)
            if (w < 0 && r[(m_last[k] + j) % 4]) w = (m_last[k] + j) % 4;
          m_last[k] = w;
          m_sel[k]  = 2'(w);
          m_word[k] = d[w*8 +: 8];
          m_ack[k]  = 4'(1 << w);
          m_act[k]  = 1'b1;
          m_e[k]    = 0;
        end
      end
    end
  end

  function automatic logic model_tx(input int k);
    int b;
    b = m_e[k] / ((k == 0) ? CPB0 : CPB1);
    if (!m_act[k]) return 1'b1;
    if (b == 0) return 1'b0;
    if (b <= W) return m_word[k][b-1];
    return 1'b1;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Every-cycle comparison of both instances against the reference.
  always @(negedge clk) begin
    check("i0_tx",   32'(if0.tx),      32'(model_tx(0)));
    check("i0_busy", 32'(if0.busy),    32'(m_act[0]));
    check("i0_ack",  32'(if0.ack),     32'(m_ack[0]));
    check("i0_sel",  32'(if0.mux_sel), 32'(m_sel[0]));
    check("i1_tx",   32'(if1.tx),      32'(model_tx(1)));
    check("i1_busy", 32'(if1.busy),    32'(m_act[1]));
    check("i1_ack",  32'(if1.ack),     32'(m_ack[1]));
    check("i1_sel",  32'(if1.mux_sel), 32'(m_sel[1]));
  end

  logic [3:0] g_ack[$];
  int         g_cyc[$];
  always @(negedge clk) if (if0.ack != 4'd0) begin g_ack.push_back(if0.ack); g_cyc.push_back(cyc); end

  logic       auto_drop = 1'b0;
  logic       auto_reraise = 1'b0;
  logic [3:0] pend = 4'd0;

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Requesters drop req on their ack and optionally re-raise the next cycle.
  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      step();
      for (int i = 0; i < 4; i++) begin
        if (auto_drop && if0.ack[i]) begin
          if0.req[i] = 1'b0;
          pend[i] = auto_reraise;
        end else if (pend[i]) begin
          if0.req[i] = 1'b1;
          pend[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic check_grants(input string nm, input int n, input logic [31:0] exp, input bit gap);
    check({nm, "_count"}, 32'(g_ack.size()), 32'(n));
    for (int i = 0; i < n && i < g_ack.size(); i++) begin
      check({nm, "_grant"}, 32'(g_ack[i]), 32'(exp[4*i +: 4]));
      if (gap && i > 0) check({nm, "_gap"}, 32'(g_cyc[i] - g_cyc[i-1]), 32'd41);
    end
  endtask

  logic [9:0] t1_bits;
  int         nb;

  initial begin
    rstb = 1'b0;
    if0.req = 4'd0; if0.data_in = '0;
    if1.req = 4'd0; if1.data_in = '0;
    repeat (3) @(posedge clk);
    #1 rstb = 1'b1;
    step();
    check("rst_tx", 32'(if0.tx), 32'd1);
    check("rst_busy", 32'(if0.busy), 32'd0);
    check("rst_ack", 32'(if0.ack), 32'd0);
    check("rst_sel", 32'(if0.mux_sel), 32'd0);

    // 1: single frame of 8'hA5 from source 0
    t1_bits = 10'b11_0100_1010;
    if0.data_in[7:0] = 8'hA5;
    if0.req = 4'b0001;
    step();
    check("t1_ack", 32'(if0.ack), 32'b0001);
    if0.req = 4'b0000;
    nb = 0;
    for (int c = 0; c < 40; c++) begin
      if (c % 4 == 2) check("t1_tx", 32'(if0.tx), 32'(t1_bits[c/4]));
      if (if0.busy) nb++;
      step();
    end
    check("t1_busy_cycles", 32'(nb), 32'd40);
    check("t1_busy_end", 32'(if0.busy), 32'd0);
    check("t1_sel", 32'(if0.mux_sel), 32'd0);

    // 2: all four requesting, re-raised after each ack
    rstb = 1'b0; step(); rstb = 1'b1;
    g_ack.delete(); g_cyc.delete();
    if0.data_in = 32'h44_33_22_11;
    auto_drop = 1'b1; auto_reraise = 1'b1;
    if0.req = 4'b1111;
    run(200);
    auto_reraise = 1'b0; pend = 4'd0; if0.req = 4'd0;
    run(45);
    check_grants("t2", 5, 32'h0001_8421, 1'b1);

    // 3: grant to 2, then 0101 must pick 0 before 2
    g_ack.delete(); g_cyc.delete();
    if0.req = 4'b0100;
    run(45);
    if0.req = 4'b0101;
    run(90);
    check_grants("t3", 3, 32'h414, 1'b0);

    // 4: source 1 raised and words changed while source 3 is on the line
    g_ack.delete(); g_cyc.delete();
    if0.data_in[31:24] = 8'h3C;
    if0.req = 4'b1000;
    run(10);
    if0.req[1] = 1'b1;
    if0.data_in[15:8]  = 8'h96;
    if0.data_in[31:24] = 8'hFF;
    run(80);
    check_grants("t4", 2, 32'h28, 1'b1);

    // 5: reset during data bit 3 of an all-zero word
    g_ack.delete(); g_cyc.delete();
    if0.data_in[7:0] = 8'h00;
    if0.req = 4'b0001;
    run(18);
    check("t5_tx_before", 32'(if0.tx), 32'd0);
    check("t5_busy_before", 32'(if0.busy), 32'd1);
    #1 rstb = 1'b0;
    #1;
    check("t5_tx_async", 32'(if0.tx), 32'd1);
    check("t5_busy_async", 32'(if0.busy), 32'd0);
    check("t5_ack_async", 32'(if0.ack), 32'd0);
    g_ack.delete(); g_cyc.delete();
    if0.req = 4'b1001;
    step();
    rstb = 1'b1;
    run(3);
    check_grants("t5", 1, 32'h1, 1'b0);
    run(50);
    if0.req = 4'd0; auto_drop = 1'b0; pend = 4'd0;
    run(45);

    // 6: one clock per bit, word 8'h00
    if1.data_in[7:0] = 8'h00;
    if1.req = 4'b0001;
    step();
    check("t6_ack", 32'(if1.ack), 32'b0001);
    if1.req = 4'd0;
    nb = 0;
    for (int c = 0; c < 12; c++) begin
      if (c < 9) check("t6_tx_low", 32'(if1.tx), 32'd0);
      else       check("t6_tx_high", 32'(if1.tx), 32'd1);
      if (if1.busy) nb++;
      step();
    end
    check("t6_busy_cycles", 32'(nb), 32'd10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
